// File: rtl/snn_frame_streamer.sv
// snn_frame_streamer: neuron-state readout engine.
// Streams a T x N state frame (dense or sparse index list) over AXI-stream.
module snn_frame_streamer #(
  parameter int T  = 4,
  parameter int N  = 16,
  parameter int W  = 16,
  parameter int AW = $clog2(T*N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          sparse,
  input  logic [W-1:0]  threshold,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [W-1:0]  m_tdata,
  output logic          m_tlast
);

  localparam int DEPTH = T * N;
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // tdata must hold every flat index plus a distinct all-ones terminator
  if (W < AW + 1) begin : g_width_check
    $error("snn_frame_streamer: W too small for sparse indices");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    TERM,
    DRAIN
  } state_t;

  state_t state, state_n;

  logic [AW:0]   cnt, cnt_n;
  logic          sparse_q;
  logic [W-1:0]  thr_q;
  logic          infl;
  logic [AW-1:0] infl_addr;
  logic          done_q, done_n;
  logic          accept;

  logic [1:0]    occ, occ_n;
  logic [1:0]    room;
  logic [1:0]    credit;
  logic          head_v, head_v_n;
  logic [W-1:0]  d0, d1, d0_n, d1_n;
  logic          l0, l1, l0_n, l1_n;

  logic          pop;
  logic          push;
  logic [W-1:0]  push_data;
  logic          push_last;
  logic          resp_hit;
  logic [W-1:0]  resp_data;
  logic          resp_last;
  logic          term_push;

  assign accept   = (state == IDLE) && start && !done_q;
  assign pop      = head_v && m_tready;
  assign room     = occ - {1'b0, pop};
  assign credit   = room + {1'b0, infl};

  assign resp_hit  = infl && (!sparse_q || (rd_data >= thr_q));
  assign resp_data = sparse_q ? {{(W-AW){1'b0}}, infl_addr}
                              : rd_data;
  assign resp_last = !sparse_q && (infl_addr == LAST_ADDR);
  assign term_push = (state == TERM) && !infl && (room < 2'd2);

  assign push      = resp_hit || term_push;
  assign push_data = term_push ? '1 : resp_data;
  assign push_last = term_push || resp_last;

  assign rd_addr  = cnt[AW-1:0];
  assign busy     = (state != IDLE) || done_q;
  assign done     = done_q;
  assign m_tvalid = head_v;
  assign m_tdata  = d0;
  assign m_tlast  = l0;

  // Sequencer: read issue, terminator and end-of-frame handling
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_en   = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SCAN;
          cnt_n   = '0;
        end
      end
      SCAN: begin
        if (credit < 2'd2) begin
          rd_en = 1'b1;
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_CNT)
            state_n = sparse_q ? TERM : DRAIN;
        end
      end
      TERM: begin
        if (term_push)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (pop && l0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Skid FIFO next state: slot 0 is the registered stream head
  always_comb begin
    occ_n = occ;
    d0_n  = d0;
    d1_n  = d1;
    l0_n  = l0;
    l1_n  = l1;
    case ({push, pop})
      2'b10: begin
        occ_n = occ + 2'd1;
        if (occ == 2'd0) begin
          d0_n = push_data;
          l0_n = push_last;
        end else begin
          d1_n = push_data;
          l1_n = push_last;
        end
      end
      2'b01: begin
        occ_n = occ - 2'd1;
        d0_n  = d1;
        l0_n  = l1;
      end
      2'b11: begin
        if (occ == 2'd1) begin
          d0_n = push_data;
          l0_n = push_last;
        end else begin
          d0_n = d1;
          l0_n = l1;
          d1_n = push_data;
          l1_n = push_last;
        end
      end
      default: ;
    endcase
    head_v_n = (occ_n != 2'd0);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      done_q    <= 1'b0;
      infl      <= 1'b0;
      infl_addr <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      done_q    <= done_n;
      infl      <= rd_en;
      infl_addr <= cnt[AW-1:0];
    end
  end

  // Frame configuration captured at an accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      sparse_q <= 1'b0;
      thr_q    <= '0;
    end else if (accept) begin
      sparse_q <= sparse;
      thr_q    <= threshold;
    end
  end

  // Skid FIFO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      occ    <= '0;
      head_v <= 1'b0;
      d0     <= '0;
      d1     <= '0;
      l0     <= 1'b0;
      l1     <= 1'b0;
    end else begin
      occ    <= occ_n;
      head_v <= head_v_n;
      d0     <= d0_n;
      d1     <= d1_n;
      l0     <= l0_n;
      l1     <= l1_n;
    end
  end

endmodule

// File: doc/snn_frame_streamer.md
# snn_frame_streamer

Parametrised readout engine for the SNN core. On a `start` pulse it walks the T×N neuron-state memory in block-major order and streams it out on an AXI-stream master port with `tlast` marking end of frame. Compared with the fixed dense dump, it adds:

- configurable geometry and data width;
- full backpressure support through a 2-entry skid buffer;
- a sparse mode that emits only the flat indices of neurons at or above a threshold, closed by a terminator beat.

It sits between the neuron-state RAM read port and the `axis_out` interface of the project top level.

## Interface
Parameters
- `T`, 4: number of neuron blocks.
- `N`, 16: neurons per block.
- `W`, 16: state / `tdata` width. Elaboration error if `W < $clog2(T*N)+1`.
- `AW`, `$clog2(T*N)`: flat address width (derived; do not override).

Ports
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle frame request; honoured only in IDLE.
- `sparse`, in, 1: mode, sampled at `start`. 0 = dense dump, 1 = threshold index list.
- `threshold`, in, W: sparse-mode compare value, sampled at `start`, unsigned.
- `busy`, out, 1: frame in progress.
- `done`, out, 1: one-cycle pulse after the final (`tlast`) handshake.
- `rd_en`, out, 1: memory read strobe.
- `rd_addr`, out, AW: flat address, `block*N + neuron`.
- `rd_data`, in, W: read data, valid exactly 1 cycle after `rd_en`.
- `m_tvalid`, out, 1: AXI-stream master valid.
- `m_tready`, in, 1: AXI-stream master ready.
- `m_tdata`, out, W: AXI-stream master data.
- `m_tlast`, out, 1: AXI-stream master last.

## Operation
- **States:** IDLE, SCAN, TERM, DRAIN.
- **IDLE.** `start` latches `sparse` and `threshold`, clears the address counter and enters SCAN. `busy` rises the next cycle.
- **SCAN, read issue.**
  - Issue `rd_en` with `rd_addr` = counter, then increment the counter.
  - Issue only when (skid occupancy + reads in flight) < 2.
  - After address `T*N-1` is issued: go to TERM if sparse, else DRAIN.
- **Dense response path.** Every response is pushed to the skid buffer as `tdata=rd_data`, with `tlast=1` only for address `T*N-1`.
- **Sparse response path.**
  - A response is pushed only if `rd_data >= threshold`, as `tdata` = zero-extended address, `tlast=0`.
  - Non-matching responses are dropped and free their credit.
- **TERM.** Once all reads have returned and skid space exists, push a terminator beat: `tdata` = all ones, `tlast=1`. Then go to DRAIN.
- **DRAIN.** Wait for the `tlast` handshake, pulse `done`, return to IDLE.
- **Skid buffer.** 2-entry FIFO; its head drives `m_tvalid`, `m_tdata` and `m_tlast` directly from registers.
- **Start rules.** `start` outside IDLE is ignored. `start` in the same cycle as `done` is also ignored; it is only accepted from the cycle after.
- **Reset mid-frame.** Reset in any state returns to IDLE and empties the skid buffer. The in-flight read response is discarded. No partial `tlast` is emitted.

## Timing
- **Reset values:** `busy=0`, `done=0`, `rd_en=0`, `rd_addr=0`, `m_tvalid=0`, `m_tdata=0`, `m_tlast=0`.
- **Dense latency.** With `start` at cycle 0: `rd_en` first at cycle 1, first `m_tvalid` at cycle 3.
- **Throughput.** With `m_tready=1` continuously: one beat per cycle, `T*N` beats, `tlast` at cycle `T*N+2`, `done` at cycle `T*N+3`.
- **AXI-stream rule.** While `m_tvalid && !m_tready`, `m_tdata` and `m_tlast` are held stable, and `m_tvalid` never drops without a handshake.
- **Backpressure.** Reads stall within 2 cycles of `m_tready` falling. No beat is lost or duplicated.
- **Sparse ordering.** Indices are emitted in ascending order. The terminator beat always follows the last match.
- **`busy`.** High from the cycle after an accepted `start` through the `done` cycle inclusive.

## Test plan
- **Dense, no backpressure.** T=4, N=4, memory[a]=3a, `m_tready=1`, `start` -> 16 beats 0,3,…,45; `tlast` only on beat 16; `done` one cycle later; 1 beat/cycle.
- **Dense, random backpressure.** Same setup, `m_tready` 50% random -> identical data sequence; stable-while-stalled assertion holds; exactly one `tlast`.
- **Sparse, two matches.** `threshold=10`, memory[1]=12, memory[9]=10, all others 5 -> beats 1, 9, then 0xFFFF with `tlast=1`.
- **Sparse, no matches.** `threshold=100`, all memory < 100 -> a single beat 0xFFFF with `tlast=1`; `done` pulses.
- **Reset mid-frame.** Assert `reset` at dense beat 6 with `m_tready=0` -> next cycle `m_tvalid=0`, `busy=0`. A following `start` produces a clean full 16-beat frame.
- **Start while busy.** Second `start` pulse mid-frame (with different `sparse`/`threshold`) -> ignored; current frame unchanged; no second frame begins.
